// File: rtl/serial_receiver_pkg.sv
//------------------------------------------------------------------------------
// Module      : serial_receiver_pkg
// Description : Shared serial-link framing constants and receiver state encoding.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package serial_receiver_pkg;

    localparam int BIT_CYCLES   = 27;
    localparam int FRAME_BITS   = 36;
    localparam int SYNC_BITS    = 4;
    localparam logic [SYNC_BITS-1:0] SYNC_PATTERN = 4'b1101;
    localparam int SAMPLE_POINT = 13;

    localparam int PAYLOAD_BITS = FRAME_BITS - SYNC_BITS;
    localparam int CYC_W        = $clog2(BIT_CYCLES);
    localparam int BIT_W        = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/serial_bit_timer.sv
//------------------------------------------------------------------------------
// Module      : serial_bit_timer
// Description : Bit-period pacing counter (cyc_cnt/bit_cnt) with sample and bit-end strobes.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_bit_timer
    import serial_receiver_pkg::*;
#(
    parameter int STROBE_AT = SAMPLE_POINT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_clear,
    output logic             o_sample,
    output logic             o_bit_end,
    output logic [BIT_W-1:0] o_bit_cnt
);

    localparam logic [CYC_W-1:0] c_last_cyc  = CYC_W'(BIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] c_strobe    = CYC_W'(STROBE_AT);
    localparam logic [BIT_W-1:0] c_first_bit = BIT_W'(FRAME_BITS - 1);

    logic [CYC_W-1:0] r_cyc_cnt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic             r_run;

    // bit_cnt wraps from 0 back to the first frame bit so a locked stream keeps pacing
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cyc_cnt <= '0;
            r_bit_cnt <= '0;
            r_run     <= 1'b0;
        end else if (i_start) begin
            r_cyc_cnt <= '0;
            r_bit_cnt <= c_first_bit;
            r_run     <= 1'b1;
        end else if (i_clear) begin
            r_cyc_cnt <= '0;
            r_bit_cnt <= '0;
            r_run     <= 1'b0;
        end else if (r_run) begin
            if (r_cyc_cnt == c_last_cyc) begin
                r_cyc_cnt <= '0;
                r_bit_cnt <= (r_bit_cnt == '0) ? c_first_bit : r_bit_cnt - 1'b1;
            end else begin
                r_cyc_cnt <= r_cyc_cnt + 1'b1;
            end
        end
    end

    assign o_sample  = r_run && (r_cyc_cnt == c_strobe);
    assign o_bit_end = r_run && (r_cyc_cnt == c_last_cyc);
    assign o_bit_cnt = r_bit_cnt;

endmodule

`default_nettype wire

// File: rtl/serial_receiver.sv
//------------------------------------------------------------------------------
// Module      : serial_receiver
// Description : Serial link receiver; recovers 36-bit frames, checks sync header,
//               emits 32-bit payload. Option: SERIAL_RECEIVER_MAJORITY_VOTE_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_receiver
    import serial_receiver_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_rx_en,
    input  logic                    i_din,
    output logic [PAYLOAD_BITS-1:0] o_rx_data,
    output logic                    o_rx_valid,
    output logic                    o_rx_error,
    output logic                    o_rx_busy
);

`ifdef SERIAL_RECEIVER_MAJORITY_VOTE_EN
    localparam int c_strobe_at = SAMPLE_POINT + 1;
`else
    localparam int c_strobe_at = SAMPLE_POINT;
`endif
    localparam logic [BIT_W-1:0] c_first_bit = BIT_W'(FRAME_BITS - 1);

    rx_state_t               r_state;
    logic [1:0]              r_sync;
    logic                    r_din_q;
    logic                    r_armed;
    logic [FRAME_BITS-1:0]   r_shreg;
    logic [PAYLOAD_BITS-1:0] r_rx_data;
    logic                    r_rx_valid;
    logic                    r_rx_error;
    logic                    r_rx_busy;

    logic                    w_din_s;
    logic                    w_rise;
    logic                    w_bit;
    logic                    w_start;
    logic                    w_clear;
    logic                    w_sample;
    logic                    w_bit_end;
    logic [BIT_W-1:0]        w_bit_cnt;
    logic [FRAME_BITS-1:0]   w_shreg_next;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync  <= '0;
            r_din_q <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_din};
            r_din_q <= r_sync[1];
        end
    end

    assign w_din_s = r_sync[1];
    assign w_rise  = w_din_s & ~r_din_q;

`ifdef SERIAL_RECEIVER_MAJORITY_VOTE_EN
    logic r_din_q2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_din_q2 <= 1'b0;
        end else begin
            r_din_q2 <= r_din_q;
        end
    end

    // History taps hold din_s from SAMPLE_POINT-1 and SAMPLE_POINT at the commit cycle
    assign w_bit = (r_din_q2 & r_din_q) | (r_din_q2 & w_din_s) | (r_din_q & w_din_s);
`else
    assign w_bit = w_din_s;
`endif

    assign w_start      = i_rx_en && (r_state == ST_IDLE) && r_armed && w_rise;
    assign w_clear      = !i_rx_en || (r_state == ST_IDLE);
    assign w_shreg_next = {r_shreg[FRAME_BITS-2:0], w_bit};

    serial_bit_timer #(
        .STROBE_AT (c_strobe_at)
    ) u_bit_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (w_start),
        .i_clear   (w_clear),
        .o_sample  (w_sample),
        .o_bit_end (w_bit_end),
        .o_bit_cnt (w_bit_cnt)
    );

    // r_armed needs a low line seen in IDLE, so a line stuck high after reset/error is ignored
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_armed    <= 1'b0;
            r_shreg    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_error <= 1'b0;
            r_rx_busy  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_error <= 1'b0;
            if (!i_rx_en) begin
                r_state   <= ST_IDLE;
                r_rx_busy <= 1'b0;
                r_armed   <= (r_state == ST_IDLE) ? (r_armed | ~w_din_s) : 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_armed <= r_armed | ~w_din_s;
                        if (w_start) begin
                            r_state   <= ST_RECV;
                            r_rx_busy <= 1'b1;
                            r_armed   <= 1'b0;
                        end
                    end
                    ST_RECV: begin
                        if (w_sample) begin
                            r_shreg <= w_shreg_next;
                            if ((w_bit_cnt == c_first_bit) && !w_bit) begin
                                r_state   <= ST_IDLE;
                                r_rx_busy <= 1'b0;
                            end else if (w_bit_cnt == '0) begin
                                r_state <= ST_CHECK;
                                if (w_shreg_next[FRAME_BITS-1 -: SYNC_BITS] == SYNC_PATTERN) begin
                                    r_rx_data  <= w_shreg_next[PAYLOAD_BITS-1:0];
                                    r_rx_valid <= 1'b1;
                                end else begin
                                    r_rx_error <= 1'b1;
                                end
                            end
                        end else if (w_bit_end && (w_bit_cnt == '0)) begin
                            r_shreg <= '0;
                        end
                    end
                    ST_CHECK: begin
                        if (r_rx_error) begin
                            r_state   <= ST_IDLE;
                            r_rx_busy <= 1'b0;
                        end else begin
                            r_state <= ST_RECV;
                        end
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_rx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;
    assign o_rx_error = r_rx_error;
    assign o_rx_busy  = r_rx_busy;

endmodule

`default_nettype wire

// File: tb/tb_serial_receiver.sv
//------------------------------------------------------------------------------
// Module      : tb_serial_receiver
// Description : Self-checking bench for serial_receiver against a frame-level model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_serial_receiver;
    import serial_receiver_pkg::*;

`ifdef SERIAL_RECEIVER_MAJORITY_VOTE_EN
    localparam int LAT = 962;
`else
    localparam int LAT = 961;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_en = 1'b0;
    logic        din = 1'b0;
    logic [31:0] rx_data;
    logic        rx_valid, rx_error, rx_busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          n_overlap = 0;
    int          err_seen_cyc = -10;
    logic        busy_after_err;
    logic [31:0] exp_data = '0;

    int          q_v_cyc[$];
    logic [31:0] q_v_data[$];
    int          q_e_cyc[$];
    int          e_v_cyc[$];
    logic [31:0] e_v_data[$];
    int          e_e_cyc[$];

    always #5 clk = ~clk;

    serial_receiver dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rx_en    (rx_en),
        .i_din      (din),
        .o_rx_data  (rx_data),
        .o_rx_valid (rx_valid),
        .o_rx_error (rx_error),
        .o_rx_busy  (rx_busy)
    );

    // cyc numbers posedges; outputs are sampled 1 ns after each one
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (rx_valid) begin
            q_v_cyc.push_back(cyc);
            q_v_data.push_back(rx_data);
        end
        if (rx_error) q_e_cyc.push_back(cyc);
        if (rx_valid && rx_error) n_overlap++;
        if (cyc == err_seen_cyc + 1) busy_after_err = rx_busy;
        if (rx_error) err_seen_cyc = cyc;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame-level model: a frame starting at posedge 'rise' yields its verdict LAT posedges later
    task automatic expect_frame(input logic [35:0] f, input int rise);
        if (f[35:32] == SYNC_PATTERN) begin
            e_v_cyc.push_back(rise + LAT);
            e_v_data.push_back(f[31:0]);
            exp_data = f[31:0];
        end else begin
            e_e_cyc.push_back(rise + LAT);
        end
    endtask

    task automatic send(input logic [35:0] f, input int max_cyc, input bit glitch, output int rise);
        int n = 0;
        rise = -1;
        for (int b = 35; b >= 0; b--) begin
            for (int c = 0; c < BIT_CYCLES; c++) begin
                if (n == max_cyc) return;
                @(negedge clk);
                if (n == 0) rise = cyc + 1;
                din = (glitch && f[b] && b < 32 && c == SAMPLE_POINT + 1) ? 1'b0 : f[b];
                n++;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din = 1'b0;
        end
    endtask

    task automatic check_events(input string tag);
        check({tag, " valid count"}, 64'(q_v_cyc.size()), 64'(e_v_cyc.size()));
        check({tag, " error count"}, 64'(q_e_cyc.size()), 64'(e_e_cyc.size()));
        for (int i = 0; i < q_v_cyc.size() && i < e_v_cyc.size(); i++) begin
            check({tag, " valid cycle"}, 64'(q_v_cyc[i]), 64'(e_v_cyc[i]));
            check({tag, " valid data"}, 64'(q_v_data[i]), 64'(e_v_data[i]));
        end
        for (int i = 0; i < q_e_cyc.size() && i < e_e_cyc.size(); i++)
            check({tag, " error cycle"}, 64'(q_e_cyc[i]), 64'(e_e_cyc[i]));
        check({tag, " held data"}, 64'(rx_data), 64'(exp_data));
        check({tag, " valid/error overlap"}, 64'(n_overlap), 64'd0);
        q_v_cyc.delete(); q_v_data.delete(); q_e_cyc.delete();
        e_v_cyc.delete(); e_v_data.delete(); e_e_cyc.delete();
    endtask

    initial begin
        int          rise, rise2, g_rise;
        logic [2:0]  r3;
        logic [3:0]  hdr;
        logic [35:0] f;
        bit          prev_good;

        rx_en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset data",  64'(rx_data),  64'd0);
        check("reset valid", 64'(rx_valid), 64'd0);
        check("reset error", 64'(rx_error), 64'd0);
        check("reset busy",  64'(rx_busy),  64'd0);
        rst = 1'b0;
        idle(5);

        send({4'b1101, 32'hDEADBEEF}, 9999, 1'b0, rise);
        expect_frame({4'b1101, 32'hDEADBEEF}, rise);
        idle(60);
        check_events("single");

        send({4'b1101, 32'h00000001}, 9999, 1'b0, rise);
        expect_frame({4'b1101, 32'h00000001}, rise);
        send({4'b1101, 32'hFFFFFFFF}, 9999, 1'b0, rise2);
        expect_frame({4'b1101, 32'hFFFFFFFF}, rise2);
        check("b2b spacing", 64'(rise2 - rise), 64'd972);
        idle(60);
        check_events("back2back");

        busy_after_err = 1'bx;
        send({4'b1001, 32'h12345678}, 9999, 1'b0, rise);
        expect_frame({4'b1001, 32'h12345678}, rise);
        idle(60);
        check("busy after error", 64'(busy_after_err), 64'd0);
        check_events("bad header");

        @(negedge clk);
        g_rise = cyc + 1;
        din = 1'b1;
        repeat (4) @(negedge clk);
        din = 1'b0;
        while (cyc < g_rise + 18) @(negedge clk);
        check("glitch busy", 64'(rx_busy), 64'd0);
        idle(60);
        check_events("glitch");
        send({4'b1101, 32'hCAFEF00D}, 9999, 1'b0, rise);
        expect_frame({4'b1101, 32'hCAFEF00D}, rise);
        idle(60);
        check_events("after glitch");

        send({4'b1101, 32'h0BADF00D}, 400, 1'b0, rise);
        rst = 1'b1;
        din = 1'b0;
        exp_data = '0;
        #1;
        check("midreset busy",  64'(rx_busy),  64'd0);
        check("midreset data",  64'(rx_data),  64'd0);
        check("midreset valid", 64'(rx_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(100);
        check_events("mid reset");
        send({4'b1101, 32'h5A5A1234}, 9999, 1'b0, rise);
        expect_frame({4'b1101, 32'h5A5A1234}, rise);
        idle(60);
        check_events("after reset");

        send({4'b1101, 32'h13579BDF}, 400, 1'b0, rise);
        rx_en = 1'b0;
        @(posedge clk);
        #1;
        check("rx_en drop busy", 64'(rx_busy), 64'd0);
        idle(60);
        rx_en = 1'b1;
        idle(5);
        check_events("rx_en drop");
        send({4'b1101, 32'h2468ACE0}, 9999, 1'b0, rise);
        expect_frame({4'b1101, 32'h2468ACE0}, rise);
        idle(60);
        check_events("after rx_en");

        prev_good = 1'b0;
        for (int k = 0; k < 8; k++) begin
            r3  = 3'($urandom);
            hdr = ($urandom_range(0, 3) != 0) ? SYNC_PATTERN : {1'b1, r3};
            f   = {hdr, 32'($urandom)};
            if (!(prev_good && $urandom_range(0, 1) == 1)) idle(60 + $urandom_range(0, 100));
            send(f, 9999, 1'b0, rise);
            expect_frame(f, rise);
            prev_good = (hdr == SYNC_PATTERN);
        end
        idle(60);
        check_events("random");

`ifdef SERIAL_RECEIVER_MAJORITY_VOTE_EN
        send({4'b1101, 32'hAAAAAAAA}, 9999, 1'b1, rise);
        expect_frame({4'b1101, 32'hAAAAAAAA}, rise);
        idle(60);
        check_events("majority vote");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
